// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: widths, reset PC, canonical NOP
// and the fetch FSM encoding.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Plain-vector state type so older tools can still read the encoding
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE  = 2'd0;
    localparam fetch_state_t S_REQ   = 2'd1;
    localparam fetch_state_t S_WAIT  = 2'd2;
    localparam fetch_state_t S_DRAIN = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch and imem.
// master = fetch stage, slave = memory.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {instr, pc} pairs between the
// imem response and decode, with single-cycle flush on redirect.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int PC_W  = 32,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [31:0]     push_instr,
    input  logic [PC_W-1:0] push_pc,
    input  logic            pop,
    input  logic            flush,
    output logic            head_valid,
    output logic [31:0]     head_instr,
    output logic [PC_W-1:0] head_pc,
    output logic [CW-1:0]   count
);
    import riscv_pkg::*;

    logic [31:0]     instr_q [DEPTH];
    logic [PC_W-1:0] pc_q    [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid;
    // A full buffer may still accept when the head leaves this cycle
    assign do_push    = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= NOP_INSTR;
                pc_q[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                instr_q[wr_ptr] <= push_instr;
                pc_q[wr_ptr]    <= push_pc;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push != do_pop) begin
                count <= do_push ? count + CW'(1) : count - CW'(1);
            end
        end
    end

    assign head_instr = instr_q[rd_ptr];
    assign head_pc    = pc_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives imem, buffers words
// for decode. Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int              XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);
    import riscv_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   count;
    logic            head_valid;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc;
    logic            full;
    logic            issue;
    logic            grant;
    logic            consume;
    logic            redirect;
    logic            push;

    assign full     = (count == CW'(BUF_DEPTH));
    assign consume  = head_valid & ~stall;
    assign redirect = consume & branch_taken;
    // At most one transaction is ever outstanding, and REQ never has one,
    // so free space in the buffer alone gates a new request.
    assign issue    = (state == S_REQ) & ~full;
    assign grant    = issue & imem.gnt;
    assign push     = (state == S_WAIT) & imem.rvalid & ~redirect;

    assign imem.req  = issue;
    assign imem.addr = fetch_pc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (grant) begin
                    state_nxt = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_nxt = S_REQ;
                end else if (redirect) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem.rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= branch_target & ~XLEN'(3);
        end else if (grant) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // fetch_pc already stepped past the word in flight while in WAIT
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .PC_W  (XLEN)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem.rdata),
        .push_pc    (fetch_pc - XLEN'(4)),
        .pop        (consume),
        .flush      (redirect),
        .head_valid (head_valid),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count)
    );

    assign instr_valid    = head_valid;
    assign instr          = head_valid ? head_instr : NOP_INSTR;
    assign instr_pc       = head_pc;
    assign instr_pc_plus4 = head_pc + XLEN'(4);

`ifdef FETCH_PERF_EN
    logic        drop;
    logic [32:0] fetched_sum;
    logic [32:0] flushed_sum;

    assign drop = imem.rvalid &
                  (((state == S_WAIT) & redirect) | (state == S_DRAIN));

    assign fetched_sum = {1'b0, perf_fetched} + 33'(push);
    assign flushed_sum = {1'b0, perf_flushed}
                       + 33'(redirect ? count : '0)
                       + 33'(drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized imem/decode stimulus checked against
// an architectural program-order model plus directed corner scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and program-order model
    logic        pending;
    logic [31:0] pend_addr;
    int          pend_delay;
    logic [31:0] exp_pc;
    int          n_consumed;
    int          n_granted;
    logic [31:0] grant_log[$];
    logic [31:0] cons_log[$];

    int          gnt_pct;
    int          stall_pct;
    int          br_pct;
    int          lat_min;
    int          lat_max;
    logic        fixed_en;
    logic [31:0] fixed_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        if ($urandom_range(3) == 0) begin
            t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        end else begin
            t = 32'($urandom_range(4095));
        end
        return t;
    endfunction

    task automatic set_knobs(input int g, input int s, input int b,
                             input int lmin, input int lmax);
        gnt_pct   = g;
        stall_pct = s;
        br_pct    = b;
        lat_min   = lmin;
        lat_max   = lmax;
        fixed_en  = 1'b0;
    endtask

    // One clock of memory + decode behaviour, checking the consumed stream
    task automatic step();
        logic        rv;
        logic        granted;
        logic [31:0] a;
        if (bus.req) begin
            checks++;
            if (pending || bus.addr[1:0] != 2'b00) begin
                errors++;
                $display("FAIL req_protocol: addr=%h outstanding=%0d, need aligned and none outstanding",
                         bus.addr, pending);
            end
        end
        rv            = pending && (pend_delay == 0);
        bus.rvalid    = rv;
        bus.rdata     = rv ? mem_word(pend_addr) : $urandom;
        bus.gnt       = ($urandom_range(99) < gnt_pct);
        stall         = ($urandom_range(99) < stall_pct);
        branch_taken  = ($urandom_range(99) < br_pct);
        branch_target = fixed_en ? fixed_tgt : rand_target();
        if (instr_valid && !stall) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc) ||
                instr_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stream: pc=%h instr=%h pc4=%h, need pc=%h instr=%h pc4=%h",
                         instr_pc, instr, instr_pc_plus4,
                         exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
            cons_log.push_back(instr_pc);
            n_consumed++;
            exp_pc = branch_taken ? (branch_target & ~32'd3) : exp_pc + 32'd4;
        end
        granted = bus.req && bus.gnt;
        a       = bus.addr;
        @(posedge clk);
        #1;
        if (rv) begin
            pending = 1'b0;
        end else if (pending) begin
            pend_delay--;
        end
        if (granted) begin
            pending    = 1'b1;
            pend_addr  = a;
            pend_delay = $urandom_range(lat_max, lat_min);
            n_granted++;
            grant_log.push_back(a);
        end
    endtask

    task automatic clear_model();
        pending    = 1'b0;
        pend_delay = 0;
        exp_pc     = RST_PC;
        n_consumed = 0;
        n_granted  = 0;
        grant_log.delete();
        cons_log.delete();
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        bus.gnt       = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata     = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b need 0", bus.req);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b need 0", instr_valid);
        end
        checks++;
        if (instr !== NOP) begin
            errors++;
            $display("FAIL reset_instr: got %h need %h", instr, NOP);
        end
        checks++;
        if (bus.addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr: got %h need %h", bus.addr, RST_PC);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %b need 0", bus.req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h need 1 %h",
                     bus.req, bus.addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int first_valid;
        reset_dut();
        set_knobs(100, 0, 0, 0, 0);
        first_valid = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (instr_valid && first_valid < 0) first_valid = k;
        end
        checks++;
        if (first_valid != 3) begin
            errors++;
            $display("FAIL stream_latency: got %0d need 3", first_valid);
        end
        checks++;
        if (cons_log.size() < 3 || cons_log[0] !== 32'h0 ||
            cons_log[1] !== 32'h4 || cons_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL stream_order: got n=%0d, need 0x0,0x4,0x8 first",
                     cons_log.size());
        end
        checks++;
        if (n_consumed < 8) begin
            errors++;
            $display("FAIL stream_rate: got %0d need >=8", n_consumed);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        set_knobs(100, 100, 0, 0, 0);
        repeat (10) step();
        checks++;
        if (bus.req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold: req=%b valid=%b pc=%h need 0 1 0",
                     bus.req, instr_valid, instr_pc);
        end
        checks++;
        if (n_granted != 2) begin
            errors++;
            $display("FAIL bp_grants: got %0d need 2", n_granted);
        end
        stall_pct = 0;
        repeat (20) step();
        checks++;
        if (cons_log.size() < 4 || cons_log[0] !== 32'h0 || cons_log[1] !== 32'h4 ||
            cons_log[2] !== 32'h8 || cons_log[3] !== 32'hC) begin
            errors++;
            $display("FAIL bp_order: got n=%0d, need 0x0,0x4,0x8,0xC first",
                     cons_log.size());
        end
    endtask

    task automatic test_redirect_wait();
        int guard;
        int idx;
        reset_dut();
        set_knobs(100, 100, 0, 3, 3);
        guard = 0;
        while (!(instr_valid && pending && pend_delay >= 1) && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL rw_setup: timeout after %0d cycles", guard);
        end
        stall_pct = 0;
        br_pct    = 100;
        fixed_en  = 1'b1;
        fixed_tgt = 32'h0000_0103;
        grant_log.delete();
        idx = cons_log.size() + 1;
        step();
        checks++;
        if (bus.req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_drain: req=%b valid=%b need 0 0", bus.req, instr_valid);
        end
        br_pct = 0;
        repeat (20) step();
        checks++;
        if (grant_log.size() == 0 || grant_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL rw_next_addr: got n=%0d first=%h need 100",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 32'hx);
        end
        checks++;
        if (cons_log.size() <= idx || cons_log[idx] !== 32'h100) begin
            errors++;
            $display("FAIL rw_next_pc: got n=%0d need pc 100 at %0d",
                     cons_log.size(), idx);
        end
    endtask

    task automatic test_redirect_rvalid();
        int guard;
        int idx;
        reset_dut();
        set_knobs(100, 100, 0, 2, 2);
        guard = 0;
        while (!(instr_valid && pending && pend_delay == 0) && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL rr_setup: timeout after %0d cycles", guard);
        end
        stall_pct = 0;
        br_pct    = 100;
        fixed_en  = 1'b1;
        fixed_tgt = 32'h0000_02AB;
        idx = cons_log.size() + 1;
        step();
        checks++;
        if (instr_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h2A8) begin
            errors++;
            $display("FAIL rr_drop: valid=%b req=%b addr=%h need 0 1 2a8",
                     instr_valid, bus.req, bus.addr);
        end
        br_pct = 0;
        repeat (12) step();
        checks++;
        if (cons_log.size() <= idx || cons_log[idx] !== 32'h2A8) begin
            errors++;
            $display("FAIL rr_next_pc: got n=%0d need pc 2a8 at %0d",
                     cons_log.size(), idx);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        reset_dut();
        set_knobs(100, 0, 0, 4, 4);
        guard = 0;
        while (!(pending && pend_delay >= 2 && n_consumed >= 1) && guard < 60) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 60) begin
            errors++;
            $display("FAIL ar_setup: timeout after %0d cycles", guard);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req !== 1'b0 || instr_valid !== 1'b0 ||
            bus.addr !== RST_PC || instr !== NOP) begin
            errors++;
            $display("FAIL ar_immediate: req=%b valid=%b addr=%h instr=%h",
                     bus.req, instr_valid, bus.addr, instr);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.rdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== RST_PC) begin
            errors++;
            $display("FAIL ar_stray: valid=%b req=%b addr=%h need 0 1 %h",
                     instr_valid, bus.req, bus.addr, RST_PC);
        end
        clear_model();
        set_knobs(100, 0, 0, 0, 1);
        repeat (20) step();
        checks++;
        if (cons_log.size() == 0 || cons_log[0] !== RST_PC) begin
            errors++;
            $display("FAIL ar_restart: got n=%0d need first pc %h",
                     cons_log.size(), RST_PC);
        end
    endtask

    task automatic test_random();
        reset_dut();
        set_knobs(70, 30, 8, 0, 3);
        repeat (3000) step();
        checks++;
        if (n_consumed < 150) begin
            errors++;
            $display("FAIL random_progress: got %0d need >=150", n_consumed);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        set_knobs(0, 0, 0, 0, 0);
        fixed_tgt = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", checks, errors);
        $finish;
    end

endmodule
